// File: rtl/signal_extend_mc.sv
// signal_extend_mc: multi-channel valid/payload stretcher with programmable hold length,
// optional retrigger, per-channel done pulse and global synchronous clear.
module signal_extend_mc #(
    parameter  int CH_NUM  = 4,
    parameter  int DATA_W  = 8,
    parameter  int MAX_EXT = 16,
    localparam int CNT_W   = $clog2(MAX_EXT + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [CH_NUM-1:0]        i_vld,
    input  logic [CH_NUM*DATA_W-1:0] i_data,
    input  logic [CNT_W-1:0]         i_ext_len,
    input  logic                     i_retrig_en,
    input  logic                     i_clr,
    output logic [CH_NUM-1:0]        o_vld,
    output logic [CH_NUM*DATA_W-1:0] o_data,
    output logic [CH_NUM-1:0]        o_done,
    output logic                     o_busy
);
    typedef enum logic {IDLE, HOLD} state_e;

    state_e                  state_q [CH_NUM];
    state_e                  state_d [CH_NUM];
    logic [CNT_W-1:0]        cnt_q   [CH_NUM];
    logic [CNT_W-1:0]        cnt_d   [CH_NUM];
    logic [CH_NUM*DATA_W-1:0] data_q, data_d;
    logic [CH_NUM-1:0]       done_q, done_d;
    logic [CNT_W-1:0]        len_m1;

    // Reload value is the clamped length minus one, so cnt==0 marks the last held cycle.
    always_comb begin
        len_m1 = (i_ext_len == '0) ? '0 :
                 (32'(i_ext_len) > 32'(MAX_EXT)) ? CNT_W'(MAX_EXT - 1) :
                 i_ext_len - CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            if (i_clr) begin
                state_d[k]                   = IDLE;
                cnt_d[k]                     = '0;
                data_d[k*DATA_W +: DATA_W]   = '0;
            end else if (i_vld[k] && (state_q[k] == IDLE || i_retrig_en || cnt_q[k] == '0)) begin
                state_d[k]                   = HOLD;
                cnt_d[k]                     = len_m1;
                data_d[k*DATA_W +: DATA_W]   = i_data[k*DATA_W +: DATA_W];
            end else if (state_q[k] == HOLD && cnt_q[k] == '0) begin
                state_d[k]                   = IDLE;
                data_d[k*DATA_W +: DATA_W]   = '0;
                done_d[k]                    = 1'b1;
            end else if (state_q[k] == HOLD) begin
                cnt_d[k]                     = cnt_q[k] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < CH_NUM; k++) begin
                state_q[k] <= IDLE;
                cnt_q[k]   <= '0;
            end
            data_q <= '0;
            done_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        for (int k = 0; k < CH_NUM; k++) o_vld[k] = (state_q[k] == HOLD);
    end

    assign o_data = data_q;
    assign o_done = done_q;
    assign o_busy = |o_vld;
endmodule

// File: tb/tb_signal_extend_mc.sv
// tb_signal_extend_mc: scenario tasks with inline checks plus a cycle-accurate scoreboard
// whose expectations come from an independent remaining-cycles model.
module tb_signal_extend_mc;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic [3:0]  i_vld = '0;
    logic [31:0] i_data = '0;
    logic [4:0]  i_ext_len = '0;
    logic        i_retrig_en = 1'b0;
    logic        i_clr = 1'b0;
    logic [3:0]  o_vld;
    logic [31:0] o_data;
    logic [3:0]  o_done;
    logic        o_busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  dn;
    } exp_t;

    exp_t       exp_q[$];
    int         rem [4];
    logic [7:0] md  [4];

    signal_extend_mc dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_vld(i_vld), .i_data(i_data),
        .i_ext_len(i_ext_len), .i_retrig_en(i_retrig_en), .i_clr(i_clr),
        .o_vld(o_vld), .o_data(o_data), .o_done(o_done), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (i_rst_n && exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (o_vld !== e.v) begin errors++; $display("FAIL sb_vld t=%0t got %h exp %h", $time, o_vld, e.v); end
            checks++;
            if (o_data !== e.d) begin errors++; $display("FAIL sb_data t=%0t got %h exp %h", $time, o_data, e.d); end
            checks++;
            if (o_done !== e.dn) begin errors++; $display("FAIL sb_done t=%0t got %h exp %h", $time, o_done, e.dn); end
            checks++;
            if (o_busy !== (|e.v)) begin errors++; $display("FAIL sb_busy t=%0t got %b exp %b", $time, o_busy, |e.v); end
        end
    end

    // Drives one cycle of inputs and queues the outputs expected after the next edge.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [4:0] len,
                        input logic rt, input logic c);
        exp_t e;
        int   l;
        @(negedge i_clk);
        #1;
        i_vld = v; i_data = d; i_ext_len = len; i_retrig_en = rt; i_clr = c;
        l = (len == 0) ? 1 : (len > 16) ? 16 : int'(len);
        e.dn = '0;
        for (int k = 0; k < 4; k++) begin
            if (c) begin
                rem[k] = 0; md[k] = 8'h00;
            end else if (rem[k] == 0) begin
                if (v[k]) begin rem[k] = l; md[k] = d[k*8 +: 8]; end
            end else if (v[k] && (rt || rem[k] == 1)) begin
                rem[k] = l; md[k] = d[k*8 +: 8];
            end else if (rem[k] == 1) begin
                rem[k] = 0; md[k] = 8'h00; e.dn[k] = 1'b1;
            end else begin
                rem[k]--;
            end
            e.v[k] = (rem[k] > 0);
            e.d[k*8 +: 8] = md[k];
        end
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin rem[k] = 0; md[k] = 8'h00; end
    endtask

    task automatic test_reset();
        #2 i_rst_n = 1'b0;
        model_reset();
        #3;
        checks++;
        if (o_vld !== 4'h0 || o_data !== 32'h0 || o_done !== 4'h0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset got vld=%h data=%h done=%h busy=%b exp all zero", o_vld, o_data, o_done, o_busy);
        end
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic ev;
        for (int c = 0; c < 8; c++) begin
            step((c == 0) ? 4'h1 : 4'h0, 32'h0000_00A5, 5'd4, 1'b0, 1'b0);
            ev = (c >= 1 && c <= 4);
            checks++;
            if (o_vld[0] !== ev || o_data[7:0] !== (ev ? 8'hA5 : 8'h00) || o_done[0] !== (c == 5) || o_busy !== ev) begin
                errors++;
                $display("FAIL single c%0d got vld=%b data=%h done=%b busy=%b exp vld=%b data=%h done=%b",
                         c, o_vld[0], o_data[7:0], o_done[0], o_busy, ev, ev ? 8'hA5 : 8'h00, c == 5);
            end
        end
    endtask

    task automatic test_retrig(input logic rt);
        logic       ev;
        logic [7:0] ed;
        int         dc;
        dc = rt ? 7 : 5;
        for (int c = 0; c < 10; c++) begin
            step((c == 0 || c == 2) ? 4'h2 : 4'h0, (c == 2) ? 32'h0000_2200 : 32'h0000_1100, 5'd4, rt, 1'b0);
            ev = rt ? (c >= 1 && c <= 6) : (c >= 1 && c <= 4);
            ed = !ev ? 8'h00 : (rt && c >= 3) ? 8'h22 : 8'h11;
            checks++;
            if (o_vld[1] !== ev || o_data[15:8] !== ed || o_done[1] !== (c == dc)) begin
                errors++;
                $display("FAIL retrig%0b c%0d got vld=%b data=%h done=%b exp vld=%b data=%h done=%b",
                         rt, c, o_vld[1], o_data[15:8], o_done[1], ev, ed, c == dc);
            end
        end
    endtask

    task automatic test_last_reload();
        logic       ev;
        logic [7:0] ed;
        for (int c = 0; c < 10; c++) begin
            step((c == 0 || c == 3) ? 4'h8 : 4'h0, (c == 3) ? 32'h0200_0000 : 32'h0100_0000, 5'd3, 1'b0, 1'b0);
            ev = (c >= 1 && c <= 6);
            ed = !ev ? 8'h00 : (c >= 4) ? 8'h02 : 8'h01;
            checks++;
            if (o_vld[3] !== ev || o_data[31:24] !== ed || o_done[3] !== (c == 7)) begin
                errors++;
                $display("FAIL last_reload c%0d got vld=%b data=%h done=%b exp vld=%b data=%h done=%b",
                         c, o_vld[3], o_data[31:24], o_done[3], ev, ed, c == 7);
            end
        end
    endtask

    task automatic test_len_bounds();
        logic ev;
        for (int c = 0; c < 4; c++) begin
            step((c == 0) ? 4'h4 : 4'h0, 32'h0033_0000, 5'd0, 1'b0, 1'b0);
            ev = (c == 1);
            checks++;
            if (o_vld[2] !== ev || o_done[2] !== (c == 2)) begin
                errors++;
                $display("FAIL len0 c%0d got vld=%b done=%b exp vld=%b done=%b", c, o_vld[2], o_done[2], ev, c == 2);
            end
        end
        for (int c = 0; c < 20; c++) begin
            step((c == 0) ? 4'h1 : 4'h0, 32'h0000_005A, 5'd20, 1'b0, 1'b0);
            ev = (c >= 1 && c <= 16);
            checks++;
            if (o_vld[0] !== ev || o_done[0] !== (c == 17)) begin
                errors++;
                $display("FAIL len20 c%0d got vld=%b done=%b exp vld=%b done=%b", c, o_vld[0], o_done[0], ev, c == 17);
            end
        end
        for (int c = 0; c < 9; c++) begin
            step((c == 0) ? 4'h2 : 4'h0, 32'h0000_7700, (c < 2) ? 5'd5 : 5'd2, 1'b0, 1'b0);
            ev = (c >= 1 && c <= 5);
            checks++;
            if (o_vld[1] !== ev || o_done[1] !== (c == 6)) begin
                errors++;
                $display("FAIL len_change c%0d got vld=%b done=%b exp vld=%b done=%b", c, o_vld[1], o_done[1], ev, c == 6);
            end
        end
    endtask

    task automatic test_clr();
        logic ev;
        for (int c = 0; c < 12; c++) begin
            step((c == 0) ? 4'hF : 4'h0, 32'h4030_2010, 5'd8, 1'b0, c == 2);
            ev = (c == 1 || c == 2);
            checks++;
            if (o_vld !== (ev ? 4'hF : 4'h0) || o_data !== (ev ? 32'h4030_2010 : 32'h0) || o_done !== 4'h0) begin
                errors++;
                $display("FAIL clr c%0d got vld=%h data=%h done=%h exp vld=%h data=%h done=0",
                         c, o_vld, o_data, o_done, ev ? 4'hF : 4'h0, ev ? 32'h4030_2010 : 32'h0);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) step((c == 0) ? 4'h5 : 4'h0, 32'h00EE_00DD, 5'd8, 1'b0, 1'b0);
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (o_vld !== 4'h0 || o_data !== 32'h0 || o_done !== 4'h0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got vld=%h data=%h done=%h busy=%b exp all zero", o_vld, o_data, o_done, o_busy);
        end
        @(negedge i_clk);
        #1 i_rst_n = 1'b1;
        test_single();
    endtask

    task automatic test_back_to_back();
        logic [3:0] v;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 4; k++) v[k] = ($urandom_range(0, 3) == 0);
            step(v, $urandom, 5'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);
        end
        for (int c = 0; c < 20; c++) step(4'h0, 32'h0, 5'd4, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_retrig(1'b1);
        test_retrig(1'b0);
        test_last_reload();
        test_len_bounds();
        test_clr();
        test_reset_mid();
        test_back_to_back();
        @(negedge i_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
